// File: rtl/monolith_pkg.sv
// Shared Monolith types: field modulus, word/state types and the sponge FSM encoding.
// Used by the sponge controller and the permutation/round blocks.
package monolith_pkg;

    localparam int unsigned WORD_W  = 31;
    localparam int unsigned STATE_N = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t state_t [STATE_N];

    // Mersenne prime 2^31 - 1
    localparam word_t P = '1;

    typedef enum logic [2:0] {
        ST_ABSORB     = 3'd0,
        ST_PAD_BLOCK  = 3'd1,
        ST_PERM_START = 3'd2,
        ST_PERM_WAIT  = 3'd3,
        ST_SQUEEZE    = 3'd4
    } sponge_state_e;

endpackage

// File: rtl/monolith_add_mod.sv
// Combinational addition modulo 2^W - 1 for canonical operands (one conditional subtract).
module monolith_add_mod #(
    parameter int unsigned W = 31
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum
);

    logic [W:0] w_p;
    logic [W:0] w_sum;
    logic [W:0] w_diff;

    assign w_p    = {1'b0, {W{1'b1}}};
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = w_sum - w_p;
    assign o_sum  = (w_sum >= w_p) ? w_diff[W-1:0] : w_sum[W-1:0];

endmodule

// File: rtl/monolith_sponge.sv
// Sponge controller feeding the Monolith permutation: absorb, pad, permute, squeeze.
// Optional input canonicity check: define MONOLITH_SPONGE_ERR_CHECK_EN.
module monolith_sponge
    import monolith_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = WORD_W,
    parameter int unsigned STATE_SIZE  = STATE_N,
    parameter int unsigned RATE        = 8,
    parameter int unsigned DIGEST_SIZE = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_WIDTH-1:0]            in_word,
    input  logic                             in_last,
    output logic                             perm_start,
    output logic [STATE_SIZE*WORD_WIDTH-1:0] perm_state_in,
    input  logic [STATE_SIZE*WORD_WIDTH-1:0] perm_state_out,
    input  logic                             perm_valid,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DIGEST_SIZE*WORD_WIDTH-1:0] digest,
    output logic                             err
);

    localparam int unsigned    SI_W  = $clog2(STATE_SIZE);
    localparam logic [WORD_WIDTH-1:0] P_MOD = '1;

    sponge_state_e           r_state, w_state_nxt;
    logic [WORD_WIDTH-1:0]   r_s [STATE_SIZE];
    logic [SI_W-1:0]         r_idx;
    logic                    r_final, r_pad_pending, r_wait_first, r_active;

    logic                    w_accept, w_blk_end, w_perm_done;
    logic [SI_W-1:0]         w_idx_inc;
    logic [WORD_WIDTH-1:0]   w_in_word, w_add_a, w_add_b, w_add_sum;
    logic [WORD_WIDTH-1:0]   w_pad_old, w_pad_inc;

    assign w_accept    = in_valid && in_ready;
    assign w_blk_end   = (r_idx == SI_W'(RATE - 1));
    assign w_idx_inc   = r_idx + 1'b1;
    assign w_perm_done = perm_valid && !r_wait_first;

`ifdef MONOLITH_SPONGE_ERR_CHECK_EN
    logic w_noncanon;
    logic r_err;
    assign w_noncanon = (in_word == P_MOD);
    assign w_in_word  = w_noncanon ? '0 : in_word;
    always_ff @(posedge clk) begin
        if (reset)
            r_err <= 1'b0;
        else if (w_accept && w_noncanon)
            r_err <= 1'b1;
    end
    assign err = r_err;
`else
    assign w_in_word = in_word;
    assign err       = 1'b0;
`endif

    // One shared adder: absorbed word in ABSORB, the padding 1 on S[0] in PAD_BLOCK.
    always_comb begin
        w_add_a = r_s[r_idx];
        w_add_b = w_in_word;
        if (r_state == ST_PAD_BLOCK) begin
            w_add_a = r_s[0];
            w_add_b = WORD_WIDTH'(1);
        end
    end

    monolith_add_mod #(.W(WORD_WIDTH)) u_add (
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .o_sum (w_add_sum)
    );

    assign w_pad_old = r_s[w_idx_inc];
    assign w_pad_inc = (w_pad_old == P_MOD - 1'b1) ? '0 : w_pad_old + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_ABSORB;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        perm_start  = 1'b1;
        case (r_state)
            ST_ABSORB: begin
                in_ready = r_active;
                if (in_valid && in_ready && (in_last || w_blk_end))
                    w_state_nxt = ST_PERM_START;
            end
            ST_PAD_BLOCK:  w_state_nxt = ST_PERM_START;
            ST_PERM_START: w_state_nxt = ST_PERM_WAIT;
            ST_PERM_WAIT: begin
                perm_start = 1'b0;
                if (w_perm_done)
                    w_state_nxt = r_final       ? ST_SQUEEZE   :
                                  r_pad_pending ? ST_PAD_BLOCK : ST_ABSORB;
            end
            ST_SQUEEZE: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_state_nxt = ST_ABSORB;
            end
            default: w_state_nxt = ST_ABSORB;
        endcase
        if (reset) begin
            in_ready   = 1'b0;
            out_valid  = 1'b0;
            perm_start = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s           <= '{default: '0};
            r_idx         <= '0;
            r_final       <= 1'b0;
            r_pad_pending <= 1'b0;
            r_wait_first  <= 1'b0;
        end else begin
            case (r_state)
                ST_ABSORB: if (w_accept) begin
                    r_s[r_idx] <= w_add_sum;
                    r_idx      <= w_idx_inc;
                    if (in_last && !w_blk_end) begin
                        r_s[w_idx_inc] <= w_pad_inc;
                        r_final        <= 1'b1;
                    end else if (in_last) begin
                        r_final       <= 1'b0;
                        r_pad_pending <= 1'b1;
                    end
                end
                ST_PAD_BLOCK: begin
                    r_s[0]        <= w_add_sum;
                    r_pad_pending <= 1'b0;
                    r_final       <= 1'b1;
                end
                ST_PERM_START: begin
                    r_idx        <= '0;
                    r_wait_first <= 1'b1;
                end
                ST_PERM_WAIT: begin
                    r_wait_first <= 1'b0;
                    if (w_perm_done)
                        for (int unsigned i = 0; i < STATE_SIZE; i++)
                            r_s[i] <= perm_state_out[i*WORD_WIDTH +: WORD_WIDTH];
                end
                ST_SQUEEZE: if (out_ready) begin
                    r_s     <= '{default: '0};
                    r_final <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < STATE_SIZE; g++) begin : g_state_out
        assign perm_state_in[g*WORD_WIDTH +: WORD_WIDTH] = r_s[g];
    end
    for (genvar g = 0; g < DIGEST_SIZE; g++) begin : g_digest_out
        assign digest[g*WORD_WIDTH +: WORD_WIDTH] = r_s[g];
    end

endmodule

// File: tb/tb_monolith_sponge.sv
// Scoreboard bench for monolith_sponge with a +1-per-word permutation stub.
// Err-check cases run when MONOLITH_SPONGE_ERR_CHECK_EN is defined.
module tb_monolith_sponge;

    localparam int unsigned W = 31;
    localparam int unsigned N = 16;
    localparam int unsigned R = 8;
    localparam int unsigned D = 8;
    localparam logic [W-1:0] PM = 31'h7FFFFFFF;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_word = '0;
    logic           in_last = 1'b0;
    logic           perm_start;
    logic [N*W-1:0] perm_state_in;
    logic [N*W-1:0] perm_state_out;
    logic           perm_valid;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [D*W-1:0] digest;
    logic           err;

    always #5 clk = ~clk;

    monolith_sponge #(
        .WORD_WIDTH  (W),
        .STATE_SIZE  (N),
        .RATE        (R),
        .DIGEST_SIZE (D)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_word        (in_word),
        .in_last        (in_last),
        .perm_start     (perm_start),
        .perm_state_in  (perm_state_in),
        .perm_state_out (perm_state_out),
        .perm_valid     (perm_valid),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .digest         (digest),
        .err            (err)
    );

    // Permutation stub: valid a few cycles after start falls, output word-wise +1 mod p
    logic [2:0] stub_cnt = '0;
    always @(posedge clk) begin
        if (perm_start)
            stub_cnt <= '0;
        else if (stub_cnt != 3'd7)
            stub_cnt <= stub_cnt + 3'd1;
    end
    assign perm_valid = (stub_cnt == 3'd3);

    always_comb begin
        perm_state_out = '0;
        for (int i = 0; i < N; i++)
            perm_state_out[i*W +: W] = (perm_state_in[i*W +: W] == PM - 1'b1) ? '0
                                      : perm_state_in[i*W +: W] + 1'b1;
    end

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference sponge model
    logic [W-1:0]   ms [N];
    logic [W-1:0]   msg [$];
    logic [N*W-1:0] q_perm [$];
    logic [D*W-1:0] q_dig [$];

    function automatic logic [W-1:0] madd(input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned t;
        t = (longint'(a) + longint'(b)) % longint'(PM);
        return t[W-1:0];
    endfunction

    function automatic logic [N*W-1:0] model_state();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = ms[i];
        return v;
    endfunction

    function automatic logic [D*W-1:0] pack_d(input logic [W-1:0] a [D]);
        logic [D*W-1:0] v;
        for (int i = 0; i < D; i++) v[i*W +: W] = a[i];
        return v;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) ms[i] = '0;
    endtask

    task automatic model_perm();
        q_perm.push_back(model_state());
        for (int i = 0; i < N; i++) ms[i] = madd(ms[i], 1);
    endtask

    task automatic model_msg();
        int unsigned idx = 0;
        logic [W-1:0] wv;
        logic [W-1:0] dg [D];
        for (int i = 0; i < msg.size(); i++) begin
            wv = (msg[i] == PM) ? '0 : msg[i];
            ms[idx] = madd(ms[idx], wv);
            if (i == msg.size() - 1) begin
                if (idx < R - 1) begin
                    ms[idx+1] = madd(ms[idx+1], 1);
                    model_perm();
                end else begin
                    model_perm();
                    ms[0] = madd(ms[0], 1);
                    model_perm();
                end
                for (int k = 0; k < D; k++) dg[k] = ms[k];
                q_dig.push_back(pack_d(dg));
                model_clear();
            end else if (idx == R - 1) begin
                model_perm();
                idx = 0;
            end else begin
                idx++;
            end
        end
    endtask

    // Monitor: each falling edge of perm_start is one permutation launch
    int unsigned    n_perms = 0;
    logic           ps_prev = 1'b1;
    logic [W-1:0]   last_perm0 = '0;
    logic [N*W-1:0] exp_perm;
    always @(negedge clk) begin
        if (!reset && ps_prev && !perm_start) begin
            n_perms++;
            last_perm0 = perm_state_in[W-1:0];
            check("perm_expected", 512'(q_perm.size() > 0), 512'(1));
            if (q_perm.size() > 0) begin
                exp_perm = q_perm.pop_front();
                check("perm_state_in", perm_state_in, exp_perm);
            end
        end
        ps_prev = perm_start;
    end

    // All stimulus tasks are entered and left on a falling edge
    task automatic send_msg();
        int unsigned t;
        model_msg();
        for (int i = 0; i < msg.size(); i++) begin
            in_valid = 1'b1;
            in_word  = msg[i];
            in_last  = (i == msg.size() - 1);
            t = 0;
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) check("in_ready_timeout", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    logic [D*W-1:0] last_digest = '0;

    task automatic recv_digest(input int unsigned hold);
        int unsigned t = 0;
        logic [D*W-1:0] exp_d;
        while (!out_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("out_valid_seen", out_valid, 1);
        check("dig_expected", 512'(q_dig.size() > 0), 512'(1));
        exp_d = (q_dig.size() > 0) ? q_dig.pop_front() : '0;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_digest", digest, exp_d);
            check("hold_in_ready", in_ready, 0);
        end
        check("digest", digest, exp_d);
        last_digest = digest;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_hs", in_ready, 1);
        check("state_cleared", perm_state_in, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_perm_start"}, perm_start, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_digest"}, digest, 0);
        check({tag, "_state"}, perm_state_in, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic release_reset();
        reset = 1'b0;
        #1;
        check("in_ready_at_release", in_ready, 0);
        @(negedge clk);
        check("in_ready_after_release", in_ready, 1);
    endtask

    initial begin
        logic [W-1:0] e [D];
        int unsigned p0;
        int unsigned t;

        model_clear();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        release_reset();

        // Three-word message, padding lands in the same block
        msg = '{31'd1, 31'd2, 31'd3};
        p0 = n_perms;
        send_msg();
        recv_digest(0);
        check("tp1_perm_count", n_perms - p0, 1);
        e = '{31'd2, 31'd3, 31'd4, 31'd2, 31'd1, 31'd1, 31'd1, 31'd1};
        check("tp1_digest", last_digest, pack_d(e));

        // Full-rate message forces an extra padding block
        msg = '{31'd1, 31'd2, 31'd3, 31'd4, 31'd5, 31'd6, 31'd7, 31'd8};
        p0 = n_perms;
        send_msg();
        recv_digest(0);
        check("tp2_perm_count", n_perms - p0, 2);
        check("tp2_perm2_s0", last_perm0, 3);
        e = '{31'd4, 31'd4, 31'd5, 31'd6, 31'd7, 31'd8, 31'd9, 31'd10};
        check("tp2_digest", last_digest, pack_d(e));

        // Modular wrap: S[0] = p-1 after first block, then absorb 5
        msg = '{31'h7FFFFFFD, 31'd0, 31'd0, 31'd0, 31'd0, 31'd0, 31'd0, 31'd0, 31'd5};
        send_msg();
        recv_digest(0);
        check("tp3_wrap_s0", last_perm0, 4);

        // Back-pressure on the digest
        msg = '{31'd7, 31'd9};
        send_msg();
        recv_digest(10);

        // Reset while the permutation is in flight
        msg = '{31'd4, 31'd5, 31'd6};
        send_msg();
        t = 0;
        while (perm_start && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("reached_perm_wait", perm_start, 0);
        @(negedge clk);
        reset = 1'b1;
        q_dig.delete();
        q_perm.delete();
        model_clear();
        @(negedge clk);
        check_reset_outputs("midrst");
        release_reset();
        msg = '{31'd1};
        send_msg();
        recv_digest(0);
        e = '{31'd2, 31'd2, 31'd1, 31'd1, 31'd1, 31'd1, 31'd1, 31'd1};
        check("tp5_digest", last_digest, pack_d(e));

`ifdef MONOLITH_SPONGE_ERR_CHECK_EN
        // Non-canonical word flags err and is absorbed as zero
        check("err_before", err, 0);
        msg = '{31'h7FFFFFFF, 31'd3};
        send_msg();
        check("err_set", err, 1);
        recv_digest(0);
        check("err_sticky", err, 1);
        reset = 1'b1;
        q_dig.delete();
        q_perm.delete();
        model_clear();
        @(negedge clk);
        check("err_cleared", err, 0);
        release_reset();
`else
        check("err_tied_low", err, 0);
`endif

        repeat (5) @(negedge clk);
        check("perm_q_drained", q_perm.size(), 0);
        check("dig_q_drained", q_dig.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
